// File: rtl/cpu_fetch_if.sv
// Fetch unit bus, consumer and control signals.
// master = fetch unit side, slave = memory/consumer side.
interface cpu_fetch_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] bus_addr;
  logic            bus_req;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_ready;
  logic            instr_valid;
  logic [XLEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            fetch_fault;
  logic [XLEN-1:0] fault_pc;

  modport master (
    output bus_addr, bus_req, instr_valid, instr_data, instr_pc, fetch_fault, fault_pc,
    input  bus_rdata, bus_ready, instr_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  bus_addr, bus_req, instr_valid, instr_data, instr_pc, fetch_fault, fault_pc,
    output bus_rdata, bus_ready, instr_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/cpu_fetch_unit.sv
// Sequential instruction prefetcher: single-outstanding bus fetch into a DEPTH-entry
// queue, with redirect flush, halt, and sticky bus-timeout fault.
module cpu_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4,
  parameter int              TIMEOUT  = 16
) (
  input logic         clk,
  input logic         reset_n,
  cpu_fetch_if.master fif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, FULL, HALTED, FAULT} state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic            fault_q, fault_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WW-1:0]   wait_q, wait_d;
  entry_t          mem_q [DEPTH];
  logic            push, pop;

  // Outputs are gated by reset so nothing is requested or presented while held in reset.
  assign fif.bus_req     = reset_n && (state_q == RUN);
  assign fif.bus_addr    = fetch_pc_q;
  assign fif.instr_valid = reset_n && (count_q != '0);
  assign fif.instr_data  = mem_q[head_q].data;
  assign fif.instr_pc    = mem_q[head_q].pc;
  assign fif.fetch_fault = fault_q;
  assign fif.fault_pc    = fault_pc_q;

  assign push = fif.bus_req && fif.bus_ready && (count_q != CW'(DEPTH)) && !fif.redirect_valid;
  assign pop  = fif.instr_valid && fif.instr_ready && !fif.redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_pc_d = fault_pc_q;
    fault_d    = fault_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wait_d     = wait_q;
    if (fif.redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      wait_d     = '0;
      fault_d    = 1'b0;
      fetch_pc_d = fif.redirect_pc;
      state_d    = fif.halt ? HALTED : RUN;
    end else begin
      if (push) begin
        tail_d     = tail_q + 1'b1;
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      end
      if (pop) head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      wait_d  = (fif.bus_req && !fif.bus_ready) ? wait_q + 1'b1 : '0;
      unique case (state_q)
        RUN: begin
          if (wait_d == WW'(TIMEOUT)) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = fetch_pc_q;
          end else if (fif.halt) begin
            state_d = HALTED;
          end else if (count_d == CW'(DEPTH)) begin
            state_d = FULL;
          end
        end
        FULL:    state_d = fif.halt ? HALTED : ((count_d == CW'(DEPTH)) ? FULL : RUN);
        HALTED:  if (!fif.halt) state_d = (count_d == CW'(DEPTH)) ? FULL : RUN;
        FAULT:   state_d = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      fault_pc_q <= '0;
      fault_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_pc_q <= fault_pc_d;
      fault_q    <= fault_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
    end
  end

  // Queue storage needs no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{pc: fetch_pc_q, data: fif.bus_rdata};
  end
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit with a fetch-order scoreboard.
module tb_cpu_fetch_unit;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [XLEN-1:0] mpc;

  cpu_fetch_if #(.XLEN(XLEN)) fif ();

  cpu_fetch_unit #(
    .XLEN(XLEN), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fif(fif)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] word(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model drives rdata, scoreboard tracks fetch order, then advance to next negedge.
  task automatic cycle();
    exp_t e;
    fif.bus_rdata = word(fif.bus_addr);
    #1;
    if (!reset_n) begin
      sb.delete();
      mpc = 32'h0;
    end else if (fif.redirect_valid) begin
      sb.delete();
      mpc = fif.redirect_pc;
    end else begin
      chk("valid_vs_model", fif.instr_valid, (sb.size() != 0));
      if (fif.bus_req) chk("bus_addr_seq", fif.bus_addr, mpc);
      if (fif.instr_valid && fif.instr_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_pc", fif.instr_pc, e.pc);
        chk("pop_data", fif.instr_data, e.data);
      end
      if (fif.bus_req && fif.bus_ready) begin
        sb.push_back('{pc: mpc, data: word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    fif.bus_ready = 1'b0;
    fif.bus_rdata = '0;
    fif.instr_ready = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc = '0;
    fif.halt = 1'b0;
    mpc = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", fif.bus_req, 1'b0);
    chk("rst_instr_valid", fif.instr_valid, 1'b0);
    chk("rst_fault", fif.fetch_fault, 1'b0);
    chk("rst_fault_pc", fif.fault_pc, 32'h0);
    chk("rst_addr", fif.bus_addr, 32'h0);

    // Fill: four back-to-back fetches, then FULL stops requesting
    reset_n = 1'b1;
    fif.bus_ready = 1'b1;
    #1;
    chk("first_req", fif.bus_req, 1'b1);
    chk("first_addr", fif.bus_addr, 32'h0);
    repeat (4) cycle();
    chk("full_no_req", fif.bus_req, 1'b0);
    chk("full_valid", fif.instr_valid, 1'b1);
    chk("full_head_pc", fif.instr_pc, 32'h0);
    chk("full_next_addr", fif.bus_addr, 32'h10);

    // Drain four while refilling
    for (int i = 0; i < 4; i++) begin
      fif.instr_ready = 1'b1;
      chk("drain_nogap", fif.instr_valid, 1'b1);
      chk("drain_pc", fif.instr_pc, 32'(i * 4));
      cycle();
    end
    fif.instr_ready = 1'b0;
    chk("refill_head", fif.instr_pc, 32'h10);
    chk("refill_req", fif.bus_req, 1'b1);
    chk("refill_addr", fif.bus_addr, 32'h1C);

    // Redirect with simultaneous completion and pop
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'h100;
    fif.instr_ready = 1'b1;
    chk("redir_busy", fif.bus_req, 1'b1);
    cycle();
    fif.redirect_valid = 1'b0;
    fif.instr_ready = 1'b0;
    fif.bus_ready = 1'b0;
    chk("redir_empty", fif.instr_valid, 1'b0);
    chk("redir_addr", fif.bus_addr, 32'h100);
    chk("redir_req", fif.bus_req, 1'b1);
    cycle();
    fif.bus_ready = 1'b1;
    cycle();
    fif.bus_ready = 1'b0;
    chk("redir_head_pc", fif.instr_pc, 32'h100);
    chk("redir_head_data", fif.instr_data, word(32'h100));
    fif.instr_ready = 1'b1;
    cycle();
    fif.instr_ready = 1'b0;

    // Bus timeout at 0x20
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'h20;
    cycle();
    fif.redirect_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("stall_req", fif.bus_req, 1'b1);
      chk("stall_nofault", fif.fetch_fault, 1'b0);
      cycle();
    end
    chk("stall15_addr", fif.bus_addr, 32'h20);
    chk("stall15_nofault", fif.fetch_fault, 1'b0);
    cycle();
    chk("fault_set", fif.fetch_fault, 1'b1);
    chk("fault_pc", fif.fault_pc, 32'h20);
    chk("fault_no_req", fif.bus_req, 1'b0);
    fif.bus_ready = 1'b1;
    cycle();
    chk("fault_sticky", fif.fetch_fault, 1'b1);
    chk("fault_still_no_req", fif.bus_req, 1'b0);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'h40;
    cycle();
    fif.redirect_valid = 1'b0;
    chk("fault_clear", fif.fetch_fault, 1'b0);
    chk("fault_exit_req", fif.bus_req, 1'b1);
    chk("fault_exit_addr", fif.bus_addr, 32'h40);
    repeat (2) cycle();

    // Halt with two entries queued
    fif.halt = 1'b1;
    fif.bus_ready = 1'b0;
    cycle();
    chk("halt_no_req", fif.bus_req, 1'b0);
    fif.bus_ready = 1'b1;
    fif.instr_ready = 1'b1;
    chk("halt_head0", fif.instr_pc, 32'h40);
    cycle();
    chk("halt_no_req2", fif.bus_req, 1'b0);
    chk("halt_head1", fif.instr_pc, 32'h44);
    cycle();
    chk("halt_drained", fif.instr_valid, 1'b0);
    cycle();
    chk("underflow_guard", fif.instr_valid, 1'b0);
    chk("halt_no_req3", fif.bus_req, 1'b0);
    fif.halt = 1'b0;
    fif.instr_ready = 1'b0;
    cycle();
    chk("resume_req", fif.bus_req, 1'b1);
    chk("resume_addr", fif.bus_addr, 32'h48);
    cycle();
    chk("resume_head", fif.instr_pc, 32'h48);

    // Address wrap
    fif.redirect_valid = 1'b1;
    fif.redirect_pc = 32'hFFFF_FFFC;
    cycle();
    fif.redirect_valid = 1'b0;
    chk("wrap_addr0", fif.bus_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr1", fif.bus_addr, 32'h0);
    cycle();
    fif.bus_ready = 1'b0;
    chk("wrap_head0", fif.instr_pc, 32'hFFFF_FFFC);
    fif.instr_ready = 1'b1;
    cycle();
    chk("wrap_head1", fif.instr_pc, 32'h0);
    cycle();
    fif.instr_ready = 1'b0;
    chk("wrap_drained", fif.instr_valid, 1'b0);

    // Reset in the middle of a stalled request
    reset_n = 1'b0;
    fif.bus_ready = 1'b1;
    #1;
    chk("midrst_no_req", fif.bus_req, 1'b0);
    cycle();
    reset_n = 1'b1;
    fif.bus_ready = 1'b0;
    fif.instr_ready = 1'b1;
    chk("midrst_empty", fif.instr_valid, 1'b0);
    chk("midrst_addr", fif.bus_addr, 32'h0);
    cycle();
    chk("midrst_underflow", fif.instr_valid, 1'b0);
    fif.bus_ready = 1'b1;
    fif.instr_ready = 1'b0;
    cycle();
    chk("midrst_valid", fif.instr_valid, 1'b1);
    chk("midrst_pc", fif.instr_pc, 32'h0);
    chk("midrst_data", fif.instr_data, word(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_fetch_unit.md
CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-004 SHALL have parameter PC_STEP, default 4, address increment per fetched word.
REQ-005 SHALL have parameter TIMEOUT, default 16, bus wait cycles before fault (>=1).
REQ-006 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port bus_addr  output  XLEN  fetch address.
REQ-009 SHALL have port bus_req  output  1  fetch request.
REQ-010 SHALL have port bus_rdata  input  XLEN  fetched word, valid when bus_req && bus_ready.
REQ-011 SHALL have port bus_ready  input  1  bus completes the request in this cycle.
REQ-012 SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-013 SHALL have port instr_data  output  XLEN  instruction word at queue head.
REQ-014 SHALL have port instr_pc  output  XLEN  address of instr_data.
REQ-015 SHALL have port instr_ready  input  1  consumer accepts head this cycle.
REQ-016 SHALL have port redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-017 SHALL have port redirect_pc  input  XLEN  new fetch address.
REQ-018 SHALL have port halt  input  1  stop issuing new bus requests.
REQ-019 SHALL have port fetch_fault  output  1  sticky bus-timeout indication.
REQ-020 SHALL have port fault_pc  output  XLEN  address that timed out.

Function
REQ-021 SHALL implement FSM states RUN, FULL, HALTED, FAULT.
REQ-022 SHALL drive bus_req=1 only in RUN; bus_addr SHALL equal fetch_pc register at all times.
REQ-023 SHALL hold bus_addr stable while bus_req=1 and bus_ready=0.
REQ-024 SHALL treat bus_req && bus_ready as completion: push {fetch_pc, bus_rdata} to queue tail, fetch_pc += PC_STEP (mod 2^XLEN wrap).
REQ-025 SHALL have at most one outstanding request; response is same-cycle, nothing is in flight across edges.
REQ-026 SHALL drive instr_valid=(count!=0); instr_data/instr_pc from head entry, registered storage, no bus-to-consumer combinational path.
REQ-027 SHALL pop the head when instr_valid && instr_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-028 SHALL transition RUN->FULL when count reaches DEPTH; FULL->RUN on the cycle after a pop.
REQ-029 SHALL transition RUN/FULL->HALTED while halt=1; queue continues to drain; HALTED->RUN (or FULL) when halt=0.
REQ-030 SHALL, on redirect_valid, clear the queue (count=0), discard any same-cycle bus completion, discard any same-cycle pop, set fetch_pc=redirect_pc, clear wait counter.
REQ-031 SHALL give redirect priority over push, pop, halt and timeout in the same cycle.
REQ-032 SHALL count consecutive cycles with bus_req=1 && bus_ready=0; reset counter on completion.
REQ-033 SHALL, when the counter reaches TIMEOUT, enter FAULT, set fetch_fault=1, fault_pc=fetch_pc, drop bus_req.
REQ-034 SHALL keep queue drainable in FAULT; leave FAULT only by redirect (fetch_fault cleared, state RUN, or HALTED if halt=1).
REQ-035 SHALL ignore instr_ready when instr_valid=0 (no underflow); never push when count=DEPTH (no overflow).
REQ-036 SHALL produce first bus_req=1 on the first cycle after reset_n deasserts, address RESET_PC.

Reset
REQ-037 SHALL, on clk edge with reset_n=0: state=RUN, fetch_pc=RESET_PC, count=0, head/tail pointers=0, wait counter=0, fetch_fault=0, fault_pc=0.
REQ-038 SHALL hold bus_req=0 and instr_valid=0 while reset_n=0; reset mid-request SHALL abandon it with no queue write.

Verification
REQ-039 SHALL verify: reset, bus_ready=1 always, instr_ready=0 -> requests at 0x0,0x4,0x8,0xC, then FULL, bus_req=0, instr_pc=0x0.
REQ-040 SHALL verify: full queue, instr_ready=1 for 4 cycles, bus_ready=1 -> pops 0x0..0xC in order, refills from 0x10, no gap in instr_valid after first pop.
REQ-041 SHALL verify: redirect_valid=1, redirect_pc=0x100 with bus completion and pop same cycle -> next cycle count=0, instr_valid=0, bus_addr=0x100, discarded word never appears.
REQ-042 SHALL verify: bus_ready=0 for 16 cycles at 0x20 -> fetch_fault=1, fault_pc=0x20, bus_req=0; redirect to 0x40 -> fetch_fault=0, bus_req=1 at 0x40.
REQ-043 SHALL verify: halt=1 with 2 entries queued -> no bus_req, both entries drain; halt=0 -> fetch resumes at next sequential address.
REQ-044 SHALL verify: redirect_pc=0xFFFFFFFC, XLEN=32 -> fetches 0xFFFFFFFC then 0x00000000 (wrap).
